// File: rtl/gelato_types_pkg.sv
// Shared types and width defaults for the gelato memory arbiter slice.
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 32
`endif
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif

package gelato_types;

    localparam int unsigned NUM_REQ_DEF = 4;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT
    } status_t;

endpackage

// File: rtl/gelato_rr_picker.sv
// Combinational round-robin picker: first set bit of req at or after rr_ptr.
module gelato_rr_picker
    import gelato_types::*;
#(
    parameter int unsigned NUM_REQ = NUM_REQ_DEF
) (
    input  logic [NUM_REQ-1:0]         req,
    input  logic [$clog2(NUM_REQ)-1:0] rr_ptr,
    output logic                       found,
    output logic [$clog2(NUM_REQ)-1:0] index
);

    localparam int unsigned IDW = $clog2(NUM_REQ);

    logic [IDW-1:0] cand;

    always_comb begin
        found = 1'b0;
        index = '0;
        cand  = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            cand = IDW'((32'(rr_ptr) + i) % NUM_REQ);
            if (!found && req[cand]) begin
                found = 1'b1;
                index = cand;
            end
        end
    end

endmodule

// File: rtl/gelato_mem_arbiter.sv
// Round-robin arbiter sharing one RAM port among NUM_REQ requesters.
module gelato_mem_arbiter
    import gelato_types::*;
#(
    parameter int unsigned NUM_REQ    = NUM_REQ_DEF,
    parameter int unsigned ADDR_WIDTH = `ADDR_WIDTH,
    parameter int unsigned DATA_WIDTH = `DATA_WIDTH
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          rdy,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ-1:0]            req_write,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_wdata,
    output logic [NUM_REQ-1:0]            req_done,
    output logic [DATA_WIDTH-1:0]         req_rdata,
    output logic                          ram_valid,
    output logic                          ram_write,
    output logic [ADDR_WIDTH-1:0]         ram_addr,
    output logic [DATA_WIDTH-1:0]         ram_wdata,
    input  logic                          ram_done,
    input  logic [DATA_WIDTH-1:0]         ram_rdata,
    output logic                          busy,
    output logic [$clog2(NUM_REQ)-1:0]    grant_id
);

    localparam int unsigned IDW = $clog2(NUM_REQ);

    status_t         state, state_d;
    logic [IDW-1:0]  rr_ptr;
    logic [IDW-1:0]  pick_idx;
    logic            pick_found;
    logic            grant_en;
    logic            complete_en;
    logic [ADDR_WIDTH-1:0] sel_addr;
    logic [DATA_WIDTH-1:0] sel_wdata;

    gelato_rr_picker #(.NUM_REQ(NUM_REQ)) u_picker (
        .req    (req_valid),
        .rr_ptr (rr_ptr),
        .found  (pick_found),
        .index  (pick_idx)
    );

    always_comb begin
        sel_addr  = '0;
        sel_wdata = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (pick_idx == IDW'(i)) begin
                sel_addr  = req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
                sel_wdata = req_wdata[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else if (rdy) begin
            state <= state_d;
        end
    end

    always_comb begin
        state_d     = state;
        grant_en    = 1'b0;
        complete_en = 1'b0;
        case (state)
            IDLE: begin
                if (pick_found) begin
                    grant_en = 1'b1;
                    state_d  = ISSUE;
                end
            end
            ISSUE: state_d = WAIT;
            WAIT: begin
                if (ram_done) begin
                    complete_en = 1'b1;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign ram_valid = (state == ISSUE);
    assign busy      = (state != IDLE);

    // Request fields are captured only at grant, so they stay stable while busy
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr    <= '0;
            grant_id  <= '0;
            ram_write <= 1'b0;
            ram_addr  <= '0;
            ram_wdata <= '0;
            req_done  <= '0;
            req_rdata <= '0;
        end else if (rdy) begin
            req_done <= '0;
            if (grant_en) begin
                grant_id  <= pick_idx;
                ram_write <= req_write[pick_idx];
                ram_addr  <= sel_addr;
                ram_wdata <= sel_wdata;
            end
            if (complete_en) begin
                req_done <= NUM_REQ'(1) << grant_id;
                if (!ram_write) begin
                    req_rdata <= ram_rdata;
                end
                rr_ptr <= (grant_id == IDW'(NUM_REQ - 1)) ? '0 : grant_id + 1'b1;
            end
        end
    end

endmodule

// File: doc/gelato_mem_arbiter.md
GELATO_MEM_ARBITER -- requirements
Module: gelato_mem_arbiter

Interface
REQ-001 Parameter NUM_REQ, default 4, SHALL set the number of requesters (LSUs or fetch units) sharing one RAM port.
REQ-002 Parameter ADDR_WIDTH, default 32, SHALL set the address width; DATA_WIDTH, default 32, SHALL set the data width.
REQ-003 Port clk, input, 1 bit, SHALL be the single clock; all state updates on its rising edge.
REQ-004 Port rst_n, input, 1 bit, SHALL be the asynchronous, active-low reset.
REQ-005 rdy, input, 1 bit: global enable; when low, all state SHALL hold.
REQ-006 req_valid / req_write, input, NUM_REQ bits each: per-requester request and write flag.
REQ-007 req_addr, input, NUM_REQ*ADDR_WIDTH: requester i occupies slice [(i+1)*ADDR_WIDTH-1 : i*ADDR_WIDTH].
REQ-008 req_wdata, input, NUM_REQ*DATA_WIDTH: store data, sliced the same way.
REQ-009 req_done, output, NUM_REQ bits: one-cycle completion pulse per requester.
REQ-010 req_rdata, output, DATA_WIDTH: load data, valid when any req_done bit is high.
REQ-011 ram_valid / ram_write, output, 1 bit each; ram_addr, output, ADDR_WIDTH; ram_wdata, output, DATA_WIDTH: downstream request.
REQ-012 ram_done, input, 1 bit; ram_rdata, input, DATA_WIDTH: downstream completion and load data.
REQ-013 busy, output, 1 bit; grant_id, output, $clog2(NUM_REQ) bits: current owner.

Function
REQ-014 FSM SHALL have states IDLE, ISSUE, WAIT.
REQ-015 IDLE: if any req_valid is set, SHALL pick winner by round-robin starting at pointer rr_ptr, latch its write/addr/wdata and grant_id, then go to ISSUE; else stay.
REQ-016 ISSUE: SHALL drive ram_valid=1 with the latched fields for exactly one cycle, then go to WAIT.
REQ-017 WAIT: ram_valid SHALL be 0; on ram_done=1 SHALL pulse req_done[grant_id]=1 next cycle, register ram_rdata into req_rdata (loads only; stores leave req_rdata unchanged), set rr_ptr = grant_id+1 modulo NUM_REQ, return to IDLE.
REQ-018 Minimum latency: req_valid sampled in cycle N -> ram_valid in N+1 -> ram_done in N+2 earliest -> req_done in N+3.
REQ-019 Latched fields SHALL NOT change while busy; requester deasserting req_valid after grant SHALL NOT abort the access; the requester still receives req_done.
REQ-020 A requester SHALL keep req_valid high until req_done; arbiter SHALL not re-grant the same request after req_done unless req_valid is still high in the following IDLE cycle.
REQ-021 ram_done while in IDLE or ISSUE SHALL be ignored.
REQ-022 rr_ptr wrap: NUM_REQ-1 +1 SHALL wrap to 0; with all requesters active, grants SHALL rotate 0,1,...,NUM_REQ-1,0.
REQ-023 busy SHALL be 1 in ISSUE and WAIT, 0 in IDLE.
REQ-024 rdy low in any state SHALL freeze FSM, outputs, and rr_ptr; a ram_done arriving while rdy is low is the downstream's responsibility to hold.

Reset
REQ-025 On rst_n low, asynchronously: state=IDLE, rr_ptr=0, grant_id=0, busy=0, ram_valid=0, ram_write=0, ram_addr=0, ram_wdata=0, req_done=0, req_rdata=0.
REQ-026 Reset mid-transaction SHALL drop the access with no req_done pulse; the requester reissues.

Structure
REQ-027 The status_t enum (IDLE/ISSUE/WAIT) and the NUM_REQ default SHALL go in gelato_types; widths SHALL use `ADDR_WIDTH/`DATA_WIDTH macros.
REQ-028 Round-robin selection SHALL be a combinational sub-module gelato_rr_picker (inputs req vector, rr_ptr; outputs found, index).

Verification
REQ-029 Single load: req_valid=0001, addr0=0x100, ram_done 2 cycles after ram_valid with rdata=0xDEADBEEF -> ram_addr=0x100, ram_write=0, req_done=0001 once, req_rdata=0xDEADBEEF.
REQ-030 All four requesting, ram_done one cycle after each ram_valid -> grant order 0,1,2,3,0, each req_done bit pulses exactly once per grant.
REQ-031 rr_ptr=3 after grant 2, only req 1 and 3 valid -> grant 3, then wrap to grant 1.
REQ-032 Store from req 2 (addr 0x40, wdata 0x55) -> ram_write=1, ram_wdata=0x55, req_rdata unchanged, req_done=0100.
REQ-033 rdy held low 3 cycles during WAIT, ram_done asserted after rdy returns -> no state change while low, req_done one cycle after ram_done.
REQ-034 rst_n asserted in WAIT -> immediately ram_valid=0, busy=0, no req_done; after release, pending req regranted from rr_ptr=0.
